sram_readout: RTL and testbench

- Read-side consumer of the capture SRAM interface.
- After a capture completes, it walks the sample memory backwards through the rd_ready/rd_valid/rd_keep/rd_data port. It serializes each word's enabled byte lanes into a byte stream for the host transmitter (UART/SPI), using a valid/ready handshake.
- Sits between the capture SRAM block and the host-link transmitter; started by the controller once the last write has been issued.

---
 rtl/ols_pkg.sv | 6 +
 rtl/lane_serializer.sv | 39 +++
 rtl/sram_readout.sv | 99 +++++++++
 tb/tb_sram_readout.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ols_pkg.sv
// ols_pkg: shared readout state encoding and lane/latency constants.
package ols_pkg;
   typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, SEND, NEXT, FIN} state_t;
   localparam int LANES = 4;
   localparam int RDLAT_DEF = 2;
endpackage

// File: rtl/lane_serializer.sv
// lane_serializer: holds one sample word and emits its enabled byte lanes, lowest first.
module lane_serializer
   import ols_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  logic [8*LANES-1:0] word,
   input  logic [LANES-1:0]   keep,
   input  logic               tx_ready,
   output logic               tx_valid,
   output logic [7:0]         tx_data,
   output logic               empty,
   output logic               last
);
   logic [8*LANES-1:0] word_q, word_d;
   logic [LANES-1:0]   lanes_q, lanes_d, low;
   always_comb begin
      low = lanes_q & -lanes_q;
      tx_valid = |lanes_q;
      empty = ~tx_valid;
      last = tx_valid && tx_ready && (lanes_q == low);
      tx_data = '0;
      for (int i = LANES - 1; i >= 0; i--)
         if (lanes_q[i]) tx_data = word_q[8*i +: 8];
      word_d = load ? word : word_q;
      lanes_d = flush ? '0 : load ? keep : (tx_valid && tx_ready) ? lanes_q & ~low : lanes_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q <= '0;
         lanes_q <= '0;
      end else begin
         word_q <= word_d;
         lanes_q <= lanes_d;
      end
   end
endmodule

// File: rtl/sram_readout.sv
// sram_readout: walks the capture SRAM backwards and streams each word's enabled bytes.
module sram_readout
   import ols_pkg::*;
#(
   parameter int MDW = 32,
   parameter int CW = 16,
   parameter int RDLAT = RDLAT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic [CW-1:0]  read_count,
   output logic           busy,
   output logic           done,
   output logic           rd_ready,
   input  logic           rd_valid,
   input  logic [3:0]     rd_keep,
   input  logic [MDW-1:0] rd_data,
   output logic           tx_valid,
   output logic [7:0]     tx_data,
   input  logic           tx_ready
);
   localparam int WW = $clog2(RDLAT + 2);
   state_t        state_q, state_d;
   logic [CW-1:0] remaining_q, remaining_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic          done_q, done_d;
   logic          load, ser_last, ser_empty;
   lane_serializer u_ser (
      .clk(clk),
      .rst(rst),
      .load(load),
      .flush(abort),
      .word(rd_data),
      .keep(rd_keep),
      .tx_ready(tx_ready),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .empty(ser_empty),
      .last(ser_last)
   );
   always_comb begin
      state_d = state_q;
      remaining_d = remaining_q;
      wcnt_d = (wcnt_q != '0) ? wcnt_q - WW'(1) : wcnt_q;
      done_d = 1'b0;
      load = 1'b0;
      case (state_q)
         IDLE:
            if (start) begin
               remaining_d = read_count;
               wcnt_d = WW'(RDLAT);
               state_d = (read_count == '0) ? FIN : WAIT;
            end
         WAIT:
            if (wcnt_q <= WW'(1) && rd_valid) state_d = CAPTURE;
         CAPTURE: begin
            load = 1'b1;
            remaining_d = remaining_q - CW'(1);
            state_d = (|rd_keep) ? SEND : NEXT;
         end
         SEND:
            if (ser_last || ser_empty) state_d = NEXT;
         NEXT: begin
            wcnt_d = WW'(RDLAT);
            state_d = (remaining_q == '0) ? FIN : WAIT;
         end
         FIN: begin
            done_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // abort beats everything, including a same-cycle start
      if (abort) begin
         state_d = IDLE;
         remaining_d = remaining_q;
         done_d = 1'b0;
         load = 1'b0;
      end
   end
   assign busy = state_q != IDLE;
   assign done = done_q;
   assign rd_ready = (state_q == NEXT) && (remaining_q != '0);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         remaining_q <= '0;
         wcnt_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         remaining_q <= remaining_d;
         wcnt_q <= wcnt_d;
         done_q <= done_d;
      end
   end
endmodule

// File: tb/tb_sram_readout.sv
// tb_sram_readout: randomized readout against an SRAM model and an expected byte stream.
module tb_sram_readout;
   localparam int RDLAT = 2;
   logic        clk = 0, rst = 0, start = 0, abort = 0, tx_ready = 0;
   logic [15:0] read_count = 0;
   logic        busy, done, rd_ready, rd_valid, tx_valid;
   logic [3:0]  rd_keep;
   logic [31:0] rd_data;
   logic [7:0]  tx_data;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   sram_readout dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .read_count(read_count),
      .busy(busy), .done(done), .rd_ready(rd_ready), .rd_valid(rd_valid),
      .rd_keep(rd_keep), .rd_data(rd_data), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready)
   );

   // SRAM: address steps down on rd_ready, output shows garbage until RDLAT cycles later
   logic [31:0] mem [256];
   logic [3:0]  kmem [256];
   logic [7:0]  addr = 8'd200, a1 = 8'd200;
   logic [31:0] garb = 0;
   logic        vr = 1;
   bit          rand_valid = 0;
   always @(posedge clk) begin
      if (rd_ready) addr <= addr - 8'd1;
      a1 <= addr;
      garb <= $urandom;
      vr <= !rand_valid || ($urandom_range(0, 3) != 0);
   end
   assign rd_data = (a1 == addr) ? mem[a1] : garb;
   assign rd_keep = (a1 == addr) ? kmem[a1] : garb[3:0];
   assign rd_valid = (a1 == addr) && vr;

   logic [7:0] rxq [$];
   int rdr_cnt = 0, done_cnt = 0, stab_err = 0, cyc = 0, last_rr = -1, min_gap = 1000;
   logic pv = 0, pr = 0, pab = 0, prst = 0;
   logic [7:0] pd = 0;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst && prst && pv && !pr && !pab && !(tx_valid && tx_data == pd)) stab_err <= stab_err + 1;
      if (tx_valid && tx_ready) rxq.push_back(tx_data);
      if (rd_ready) begin
         rdr_cnt <= rdr_cnt + 1;
         if (last_rr >= 0 && cyc - last_rr < min_gap) min_gap <= cyc - last_rr;
         last_rr <= cyc;
      end
      if (done) done_cnt <= done_cnt + 1;
      pv <= tx_valid;
      pr <= tx_ready;
      pab <= abort;
      prst <= rst;
      pd <= tx_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int k, input logic [31:0] d, input logic [3:0] kp);
      logic [7:0] ix = addr - 8'(k);
      mem[ix] = d;
      kmem[ix] = kp;
   endtask

   task automatic xfer(input string tag, input int n, input int pct, input int hold);
      logic [7:0] exp_q [$];
      logic [7:0] t = addr;
      logic [7:0] ix;
      logic [31:0] w;
      int base = rxq.size();
      int rr0 = rdr_cnt, d0 = done_cnt, s0 = stab_err;
      int lat_exp = 2, it = 0;
      bit got_done = 0;
      bit full = (pct >= 100) && (hold == 0) && !rand_valid;
      for (int k = 0; k < n; k++) begin
         ix = t - 8'(k);
         w = mem[ix];
         lat_exp += RDLAT + 2;
         for (int i = 0; i < 4; i++)
            if (kmem[ix][i]) begin
               exp_q.push_back(w[8*i +: 8]);
               lat_exp++;
            end
      end
      start = 1;
      read_count = 16'(n);
      @(posedge clk);
      #1 start = 0;
      while (it < 3000) begin
         tx_ready = (it >= hold) && ($urandom_range(1, 100) <= pct);
         it++;
         @(negedge clk);
         if (done) begin
            got_done = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!got_done) check({tag, ".timeout"}, 0, 1);
      repeat (4) @(posedge clk);
      #1;
      check({tag, ".done_cnt"}, done_cnt - d0, 1);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".nbytes"}, rxq.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s.byte%0d", tag, i), (base + i < rxq.size()) ? {24'h0, rxq[base + i]} : 32'hFFFF, exp_q[i]);
      check({tag, ".rd_ready_cnt"}, rdr_cnt - rr0, (n > 0) ? n - 1 : 0);
      check({tag, ".tx_stable"}, stab_err - s0, 0);
      if (full) check({tag, ".latency"}, it, lat_exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int d0, it, n, pct;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 0;
         kmem[i] = 0;
      end
      #1;
      check("reset_outputs", {busy, done, rd_ready, tx_valid, tx_data}, 0);
      #17 rst = 1;
      @(posedge clk);
      #1;

      set_word(0, 32'h44332211, 4'hF);
      set_word(1, 32'h88776655, 4'hF);
      set_word(2, 32'hCCBBAA99, 4'hF);
      xfer("three_full", 3, 100, 0);

      set_word(0, 32'h000000A5, 4'b0001);
      set_word(1, 32'h005A0000, 4'b0100);
      xfer("sparse", 2, 100, 0);

      set_word(0, 32'hDEADBEEF, 4'h7);
      xfer("stall", 1, 100, 8);

      xfer("zero", 0, 100, 0);

      set_word(0, 32'h11223344, 4'h0);
      set_word(1, 32'h55667788, 4'h9);
      xfer("empty_word", 2, 100, 0);

      set_word(0, 32'h44332211, 4'hF);
      set_word(1, 32'h88776655, 4'hF);
      d0 = done_cnt;
      tx_ready = 1;
      start = 1;
      read_count = 2;
      @(posedge clk);
      #1 start = 0;
      it = 0;
      while (it < 50 && !tx_valid) begin
         @(posedge clk);
         #1;
         it++;
      end
      check("abort.first_byte", {tx_valid, tx_data}, {1'b1, 8'h11});
      @(posedge clk);
      #1 tx_ready = 0;
      check("abort.second_pending", {tx_valid, tx_data}, {1'b1, 8'h22});
      abort = 1;
      @(posedge clk);
      #1 abort = 0;
      check("abort.dropped", {tx_valid, busy, rd_ready}, 0);
      repeat (5) @(posedge clk);
      #1;
      check("abort.no_done", done_cnt - d0, 0);
      xfer("after_abort", 1, 100, 0);

      set_word(0, 32'h01020304, 4'hF);
      set_word(1, 32'h05060708, 4'hF);
      set_word(2, 32'h090A0B0C, 4'hF);
      start = 1;
      read_count = 3;
      @(posedge clk);
      #1 start = 0;
      @(posedge clk);
      #3 rst = 0;
      #1;
      check("rst_mid_wait", {busy, done, rd_ready, tx_valid, tx_data}, 0);
      #10 rst = 1;
      @(posedge clk);
      #1;
      xfer("after_rst", 3, 100, 0);

      for (int r = 0; r < 12; r++) begin
         rand_valid = ($urandom_range(0, 1) == 1);
         n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++)
            set_word(k, $urandom, ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom));
         pct = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(30, 90);
         xfer($sformatf("rand%0d", r), n, pct, 0);
      end
      rand_valid = 0;

      check("rd_ready_min_gap", min_gap >= RDLAT + 2, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
